// File: rtl/aes_pkg.sv
// Shared AES definitions: tables, FSM encoding and round functions.
// The decryption core extends this with the inverse tables and functions.
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Padded to 16 entries so a 4-bit round counter indexes it directly.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = SBOX[s[8*i +: 8]];
    end
    return r;
  endfunction

  // Byte i sits at bits [127-8i -: 8]; column i/4, row i%4.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] =
          s[127-8*(4*((c+rw)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] =
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] =
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] =
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] =
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// Start/done handshake and data bus between the register wrapper
// and the AES encryption core.
interface aes_encrypt_if;

  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_DEC;
  logic         AES_DONE;
  logic [127:0] AES_MSG_ENC;

  modport master (
    output AES_START,
    output AES_KEY,
    output AES_MSG_DEC,
    input  AES_DONE,
    input  AES_MSG_ENC
  );

  modport slave (
    input  AES_START,
    input  AES_KEY,
    input  AES_MSG_DEC,
    output AES_DONE,
    output AES_MSG_ENC
  );

endinterface

// File: rtl/aes_key_step.sv
// One step of AES-128 forward key expansion:
// RotWord, SubWord, rcon XOR and the word cascade.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0  = key_i[127:96];
    w1  = key_i[95:64];
    w2  = key_i[63:32];
    w3  = key_i[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {SBOX[rot[31:24]], SBOX[rot[23:16]],
           SBOX[rot[15:8]],  SBOX[rot[7:0]]};
    t   = t ^ {rcon_i, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    key_o = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core: one round per clock with
// on-the-fly key expansion and a held ciphertext register.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  aes_encrypt_if.slave bus
);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] enc_q, enc_d;
  logic         done_q, done_d;
  logic [127:0] nk;

  aes_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (RCON[round_q]),
    .key_o  (nk)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    enc_d   = enc_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.AES_START) begin
          state_d = bus.AES_MSG_DEC ^ bus.AES_KEY;
          key_d   = bus.AES_KEY;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = mix_columns(
                    shift_rows(sub_bytes(state_q))) ^ nk;
        key_d   = nk;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) fsm_d = FINAL;
      end
      FINAL: begin
        enc_d = shift_rows(sub_bytes(state_q)) ^ nk;
        fsm_d = DONE;
      end
      DONE: begin
        if (!bus.AES_START) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

  assign bus.AES_DONE    = done_q;
  assign bus.AES_MSG_ENC = enc_q;

endmodule

// File: doc/aes_encrypt.md
# aes_encrypt

Iterative AES-128 encryption core, the forward counterpart of the team's `AES` decryption core. It shares that core's start/done handshake and port naming. It takes a 128-bit key and plaintext, executes one full AES round per clock with on-the-fly forward key expansion, and presents the ciphertext on a held output register. It sits behind the same Avalon/NIOS register wrapper as the decryption core.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed in package)

Ports:
- `CLK`  in  1  system clock, 50 MHz
- `RESET`  in  1  asynchronous, active-high reset
- `AES_START`  in  1  level request; sampled only in IDLE
- `AES_KEY`  in  128  cipher key, FIPS-197 byte 0 = bits [127:120]
- `AES_MSG_DEC`  in  128  plaintext, same byte order
- `AES_DONE`  out  1  high while ciphertext is valid and START is still high
- `AES_MSG_ENC`  out  128  ciphertext register

## Operation
- State is column-major per FIPS-197: byte i is column i/4, row i%4.
- FSM states and transitions:
  - IDLE: if `AES_START`=1 then state ← `AES_MSG_DEC` ^ `AES_KEY`, roundkey ← `AES_KEY`, round ← 1, go to ROUND.
  - ROUND: nk = key_step(roundkey, rcon[round]); state ← MixColumns(ShiftRows(SubBytes(state))) ^ nk; roundkey ← nk; round++. When round=9, go to FINAL.
  - FINAL: nk as in ROUND; `AES_MSG_ENC` ← ShiftRows(SubBytes(state)) ^ nk; go to DONE.
  - DONE: `AES_DONE`=1; on `AES_START`=0 go to IDLE.
- Inputs are captured only at the IDLE→ROUND edge. Changes to key or message mid-operation are ignored.
- `AES_START` is ignored in ROUND and FINAL.
- Holding `AES_START` high keeps the FSM in DONE. A new operation requires START low for at least one cycle.
- `AES_MSG_ENC` holds its value until the next FINAL, including through IDLE.
- MixColumns uses GF(2^8) with xtime; the reduction polynomial is 0x11B.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.

## Timing
- Reset values: FSM=IDLE, `AES_DONE`=0, `AES_MSG_ENC`=0, state/roundkey/round=0.
- Let E0 be the clock edge that samples START in IDLE.
- Rounds 1–9 occur at edges E1–E9. FINAL occurs at E10.
- `AES_DONE` rises after E10; it is a registered output decoded from the DONE state.
- Latency is 10 cycles from E0. `AES_MSG_ENC` is valid in the same cycle `AES_DONE` rises.
- `AES_DONE` falls one cycle after START is sampled low.
- Earliest restart: the second edge after `AES_DONE` falls, i.e. after one cycle in IDLE.
- Reset mid-operation (any state): immediate return to IDLE with all reset values. No partial ciphertext is exposed.

## Structure
- Package `aes_pkg` holds:
  - `SBOX` (256×8 constant)
  - `RCON` (1..10)
  - the FSM enum (IDLE, ROUND, FINAL, DONE)
  - functions `xtime`, `sub_bytes`, `shift_rows`, `mix_columns`
- This package is shared with the decryption core, which adds the inverse tables and functions.
- Sub-module `aes_key_step`: combinational. Inputs are the 128-bit key and an 8-bit rcon; the output is the next round key (RotWord, SubWord, rcon XOR, word cascade).
- Top level: FSM, round counter, state/roundkey/output registers.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, START pulse → `AES_DONE` 10 cycles after E0, `AES_MSG_ENC` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32.
  - Also check the internal roundkey after E1 = a0fafe1788542cb123a339392a6c7605.
- Round-trip: encrypt 16 random (key, pt) pairs, then feed ct and key to the `AES` decryption core → `AES_MSG_DEC` equals the original pt.
- Handshake:
  - START held high through completion → `AES_DONE` stays 1 and no restart occurs.
  - START dropped → `AES_DONE`=0 next cycle.
  - Re-raise START → the second operation produces correct ct.
  - Change key/pt during ROUND → result still matches the captured inputs.
- Reset: assert RESET at E5 of an operation → `AES_DONE`=0 and `AES_MSG_ENC`=0 immediately. After release, the C.1 vector runs correctly.
